// File: rtl/fmc_lcd_wrbuf_if.sv
// Bus bundle for the FMC-to-LCD write buffer: FMC write side, LCD replay
// side, status, and a debug view of the drain FSM state.
interface fmc_lcd_wrbuf_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  fmc_nwe;
    logic                  fmc_ne;
    logic                  fmc_rs;
    logic [23:0]           fmc_addr;
    logic                  ovf_clr;
    logic                  lcd_cs;
    logic                  lcd_rs;
    logic                  lcd_wr;
    logic [23:0]           lcd_data;
    logic                  busy;
    logic                  overflow;
    logic [DEPTH_LOG2:0]   level;
    logic [1:0]            dbg_state;

    // Driver side: the MCU/FMC model and the observer of the LCD bus.
    modport master (
        output fmc_nwe, fmc_ne, fmc_rs, fmc_addr, ovf_clr,
        input  lcd_cs, lcd_rs, lcd_wr, lcd_data, busy, overflow, level, dbg_state
    );

    // Buffer side.
    modport slave (
        input  fmc_nwe, fmc_ne, fmc_rs, fmc_addr, ovf_clr,
        output lcd_cs, lcd_rs, lcd_wr, lcd_data, busy, overflow, level, dbg_state
    );
endinterface

// File: rtl/fmc_lcd_wrbuf.sv
// FMC-to-LCD write buffer. Synchronises the FMC write strobe, captures each
// write into a FIFO of {rs, data[23:0]} entries and replays them onto the
// LCD parallel bus with programmable WR low/high times.
// dbg_state encoding: 0=IDLE, 1=SETUP, 2=WLO, 3=WHI.
module fmc_lcd_wrbuf #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WR_LOW     = 3,
    parameter int WR_HIGH    = 3
) (
    input  logic           clk,
    input  logic           rst,
    fmc_lcd_wrbuf_if.slave bus
);
    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0]          LOW_LOAD  = 4'(WR_LOW - 1);
    localparam logic [3:0]          HIGH_LOAD = 4'(WR_HIGH - 1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   LVL_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WLO   = 2'd2,
        WHI   = 2'd3
    } state_t;

    logic                  nwe_s1_q, nwe_s1_d, nwe_s2_q, nwe_s2_d;
    logic                  ne_s1_q, ne_s1_d, ne_s2_q, ne_s2_d;
    logic                  nwe_prev_q, nwe_prev_d, ne_prev_q, ne_prev_d;
    logic [24:0]           cap_q, cap_d;
    logic [24:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  overflow_q, overflow_d;
    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  lcd_cs_q, lcd_cs_d, lcd_wr_q, lcd_wr_d, lcd_rs_q, lcd_rs_d;
    logic [23:0]           lcd_data_q, lcd_data_d;
    logic                  busy_q, busy_d;
    logic                  push, push_ok, drop, pop, empty, full;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_FULL);

    // Synchroniser, capture register, push detection and FIFO bookkeeping.
    always_comb begin
        nwe_s1_d   = bus.fmc_nwe;
        nwe_s2_d   = nwe_s1_q;
        ne_s1_d    = bus.fmc_ne;
        ne_s2_d    = ne_s1_q;
        nwe_prev_d = nwe_s2_q;
        ne_prev_d  = ne_s2_q;
        cap_d      = cap_q;
        if (!nwe_s2_q && !ne_s2_q) begin
            cap_d = {bus.fmc_rs, bus.fmc_addr};
        end
        // One push per strobe: the synchronised nWE rising edge, qualified
        // by the chip enable seen in the cycle before the edge.
        push    = nwe_s2_q && !nwe_prev_q && !ne_prev_q;
        push_ok = push && (!full || pop);
        drop    = push && full && !pop;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        level_d  = level_q;
        if (push_ok && !pop) begin
            level_d = level_q + LVL_ONE;
        end else if (!push_ok && pop) begin
            level_d = level_q - LVL_ONE;
        end
        // A drop in the same cycle as a clear keeps the flag set.
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Drain FSM next state, pop decision and registered LCD outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = SETUP;
                    cnt_d   = '0;
                end
            end
            SETUP: begin
                state_d = WLO;
                cnt_d   = LOW_LOAD;
            end
            WLO: begin
                if (cnt_q == '0) begin
                    state_d = WHI;
                    cnt_d   = HIGH_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WHI: begin
                if (cnt_q == '0) begin
                    cnt_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        lcd_cs_d   = (state_d == IDLE);
        lcd_wr_d   = (state_d != WLO);
        lcd_rs_d   = lcd_rs_q;
        lcd_data_d = lcd_data_q;
        if (pop) begin
            {lcd_rs_d, lcd_data_d} = mem_q[rd_ptr_q];
        end
        busy_d = (level_d != '0) || (state_d != IDLE);
    end

    // FIFO storage; contents are don't-care after reset since pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= cap_q;
        end
    end

    // State register for synchroniser, FIFO control, FSM and outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nwe_s1_q   <= 1'b1;
            nwe_s2_q   <= 1'b1;
            ne_s1_q    <= 1'b1;
            ne_s2_q    <= 1'b1;
            nwe_prev_q <= 1'b1;
            ne_prev_q  <= 1'b1;
            cap_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            lcd_cs_q   <= 1'b1;
            lcd_wr_q   <= 1'b1;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            nwe_s1_q   <= nwe_s1_d;
            nwe_s2_q   <= nwe_s2_d;
            ne_s1_q    <= ne_s1_d;
            ne_s2_q    <= ne_s2_d;
            nwe_prev_q <= nwe_prev_d;
            ne_prev_q  <= ne_prev_d;
            cap_q      <= cap_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lcd_cs_q   <= lcd_cs_d;
            lcd_wr_q   <= lcd_wr_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_data_q <= lcd_data_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.lcd_cs    = lcd_cs_q;
    assign bus.lcd_wr    = lcd_wr_q;
    assign bus.lcd_rs    = lcd_rs_q;
    assign bus.lcd_data  = lcd_data_q;
    assign bus.busy      = busy_q;
    assign bus.overflow  = overflow_q;
    assign bus.level     = level_q;
    assign bus.dbg_state = state_q;
endmodule
